// File: rtl/nrisc_firq_ctrl.sv
// Fast-interrupt (FIRQ) sequencer for the NRISC core.
// Latches rising edges on the interrupt lines and picks the lowest-index
// enabled source. It waits for the pipeline to drain, saves the user PC and
// switches to the FIRQ register bank, then redirects fetch to the vector.
// On return-from-interrupt it restores the PC and the user bank.

module nrisc_firq_ctrl #(
    parameter int              TAM        = 16,
    parameter int              N_IRQ      = 4,
    parameter logic [TAM-1:0]  VEC_BASE   = 16'h0010,
    parameter int              VEC_STRIDE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_req,
    input  logic [N_IRQ-1:0] irq_en,
    input  logic             glb_en,
    input  logic             core_idle,
    input  logic             rfi,
    input  logic [TAM-1:0]   pc_in,
    output logic             irq_flag,
    output logic             pc_load,
    output logic [TAM-1:0]   pc_out,
    output logic [N_IRQ-1:0] irq_ack,
    output logic [2:0]       irq_id,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAIN  = 3'd1,
        S_ENTER  = 3'd2,
        S_ACTIVE = 3'd3,
        S_EXIT   = 3'd4,
        S_RETURN = 3'd5
    } state_t;

    state_t           state, state_nxt;

    logic [N_IRQ-1:0] pending, pending_nxt;
    logic [N_IRQ-1:0] req_prev;
    logic [N_IRQ-1:0] req_rise;
    logic [N_IRQ-1:0] clr;
    logic [TAM-1:0]   saved_pc, saved_pc_nxt;

    logic             cand_vld;
    logic [2:0]       cand_idx;
    logic [N_IRQ-1:0] cand_oh;
    logic [TAM-1:0]   vec_addr;

    logic             irq_flag_nxt;
    logic             pc_load_nxt;
    logic [TAM-1:0]   pc_out_nxt;
    logic [N_IRQ-1:0] irq_ack_nxt;
    logic [2:0]       irq_id_nxt;

    // Fixed-priority pick: scan downwards so the lowest enabled index wins.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = 3'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pending[i] && irq_en[i]) begin
                cand_vld = 1'b1;
                cand_idx = 3'(i);
            end
        end
        cand_vld = cand_vld & glb_en;
        for (int i = 0; i < N_IRQ; i++) begin
            cand_oh[i] = (cand_idx == 3'(i));
        end
        vec_addr = VEC_BASE + TAM'(cand_idx) * TAM'(VEC_STRIDE);
    end

    // Next-state and registered-output decode; a new edge beats a same-cycle clear.
    always_comb begin
        state_nxt    = state;
        irq_flag_nxt = irq_flag;
        pc_load_nxt  = pc_load;
        pc_out_nxt   = pc_out;
        irq_ack_nxt  = irq_ack;
        irq_id_nxt   = irq_id;
        saved_pc_nxt = saved_pc;
        clr          = '0;
        req_rise     = irq_req & ~req_prev;

        case (state)
            S_IDLE: begin
                if (cand_vld) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!cand_vld) begin
                    state_nxt = S_IDLE;
                end else if (core_idle) begin
                    state_nxt    = S_ENTER;
                    irq_id_nxt   = cand_idx;
                    saved_pc_nxt = pc_in;
                    pc_out_nxt   = vec_addr;
                    irq_flag_nxt = 1'b1;
                    pc_load_nxt  = 1'b1;
                    irq_ack_nxt  = cand_oh;
                    clr          = cand_oh;
                end
            end
            S_ENTER: begin
                state_nxt   = S_ACTIVE;
                pc_load_nxt = 1'b0;
                irq_ack_nxt = '0;
            end
            S_ACTIVE: begin
                if (rfi) state_nxt = S_EXIT;
            end
            S_EXIT: begin
                if (core_idle) begin
                    state_nxt    = S_RETURN;
                    pc_out_nxt   = saved_pc;
                    pc_load_nxt  = 1'b1;
                    irq_flag_nxt = 1'b0;
                end
            end
            S_RETURN: begin
                state_nxt   = S_IDLE;
                pc_load_nxt = 1'b0;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        pending_nxt = (pending & ~clr) | req_rise;
    end

    // State, pending/edge tracking and registered outputs; reset returns to the user bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pending  <= '0;
            req_prev <= '0;
            saved_pc <= '0;
            irq_flag <= 1'b0;
            pc_load  <= 1'b0;
            pc_out   <= '0;
            irq_ack  <= '0;
            irq_id   <= 3'd0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            req_prev <= irq_req;
            saved_pc <= saved_pc_nxt;
            irq_flag <= irq_flag_nxt;
            pc_load  <= pc_load_nxt;
            pc_out   <= pc_out_nxt;
            irq_ack  <= irq_ack_nxt;
            irq_id   <= irq_id_nxt;
        end
    end

    assign busy = (state != S_IDLE);

endmodule
